rmii_tx_framer: RTL

- Transmit-side RMII stage. Consumes payload bytes (destination MAC through end of data) from an upstream byte-wide AXI-Stream source.
- Emits a complete Ethernet frame on TXD/TX_EN, two bits per clk: 7-byte preamble, SFD, payload, zero pad to minimum size, CRC-32 FCS, then the inter-frame gap.
- Sits between the MAC transmit path and the PHY, beside the RMII receive shim. clk is the 50 MHz RMII reference clock.

---
 rtl/rmii_pkg.sv | 33 +++
 rtl/eth_crc32.sv | 22 ++
 rtl/rmii_tx_framer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/rmii_pkg.sv
// Shared RMII transmit/receive types, framing constants and byte-wise CRC-32 step.
// latency: n/a (declarations only); backpressure: n/a.
package rmii_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    PAYLOAD,
    PAD,
    FCS,
    IFG,
    DISCARD
  } tx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  // Reflected CRC-32, one byte consumed LSB-first; no final inversion.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wise Ethernet CRC-32 accumulator, shared by the transmit framer and receive checker.
// latency: crc reflects a byte one clk after en; backpressure: none, en is a plain strobe.
module eth_crc32
  import rmii_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || init) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc32_byte(crc, data);
    end
  end

endmodule

// File: rtl/rmii_tx_framer.sv
// RMII transmit framer: preamble, SFD, payload, zero pad, FCS and IFG, one dibit per clk.
// latency: TX_EN one clk after s_tvalid in IDLE; backpressure: s_tready only at byte-fetch dibits.
module rmii_tx_framer
  import rmii_pkg::*;
#(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int PREAMBLE_BYTES  = 7,
  parameter int IFG_BYTES       = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  output logic       s_tready,
  output logic       TX_EN,
  output logic [1:0] TXD,
  output logic       busy,
  output logic       underrun
);

  localparam logic [15:0] MIN_PAY  = 16'(MIN_FRAME_BYTES - 4);
  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_BYTES - 1);
  // The single IDLE cycle before a new frame completes the gap on the wire.
  localparam logic [7:0]  IFG_LAST = 8'(4 * IFG_BYTES - 2);

  tx_state_t   state, state_nx;
  logic [1:0]  dib, dib_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [15:0] pay_cnt, pay_cnt_nx;
  logic [7:0]  cur_byte, byte_nx;
  logic        last_seen, last_nx;
  logic        bad, bad_nx;
  logic        fetch;
  logic        crc_init, crc_en;
  logic [7:0]  crc_dat;
  logic [31:0] crc;
  logic        tx_en_nx;
  logic [1:0]  txd_nx;
  logic        busy_nx;

  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  // A bad frame carries the raw register, i.e. the complement of the correct FCS.
  function automatic logic [7:0] fcs_byte(input logic [31:0] c, input logic b, input logic [1:0] k);
    logic [31:0] w;
    w = b ? c : ~c;
    return w[{k, 3'b000} +: 8];
  endfunction

  eth_crc32 u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (crc_init),
    .en   (crc_en),
    .data (crc_dat),
    .crc  (crc)
  );

  always_comb begin
    state_nx   = state;
    dib_nx     = dib + 2'd1;
    cnt_nx     = cnt;
    pay_cnt_nx = pay_cnt;
    byte_nx    = cur_byte;
    last_nx    = last_seen;
    bad_nx     = bad;
    crc_init   = 1'b0;
    crc_en     = 1'b0;
    crc_dat    = s_tdata;
    fetch      = (dib == 2'd3) && ((state == SFD) || ((state == PAYLOAD) && !last_seen));
    s_tready   = fetch || (state == DISCARD);

    case (state)
      IDLE: begin
        dib_nx = 2'd0;
        if (s_tvalid) begin
          state_nx   = PREAMBLE;
          cnt_nx     = 8'd0;
          pay_cnt_nx = 16'd0;
          last_nx    = 1'b0;
          bad_nx     = 1'b0;
          crc_init   = 1'b1;
          byte_nx    = PREAMBLE_BYTE;
        end
      end
      PREAMBLE: begin
        if (dib == 2'd3) begin
          if (cnt == PRE_LAST) begin
            state_nx = SFD;
            byte_nx  = SFD_BYTE;
            cnt_nx   = 8'd0;
          end else begin
            cnt_nx = cnt + 8'd1;
          end
        end
      end
      SFD, PAYLOAD: begin
        if (fetch) begin
          if (s_tvalid) begin
            state_nx   = PAYLOAD;
            byte_nx    = s_tdata;
            last_nx    = s_tlast;
            crc_en     = 1'b1;
            pay_cnt_nx = sat_inc(pay_cnt);
          end else begin
            state_nx = FCS;
            bad_nx   = 1'b1;
            cnt_nx   = 8'd0;
            byte_nx  = fcs_byte(crc, 1'b1, 2'd0);
          end
        end else if (dib == 2'd3) begin
          if (pay_cnt < MIN_PAY) begin
            state_nx   = PAD;
            byte_nx    = 8'h00;
            crc_en     = 1'b1;
            crc_dat    = 8'h00;
            pay_cnt_nx = sat_inc(pay_cnt);
          end else begin
            state_nx = FCS;
            cnt_nx   = 8'd0;
            byte_nx  = fcs_byte(crc, bad, 2'd0);
          end
        end
      end
      PAD: begin
        if (dib == 2'd3) begin
          if (pay_cnt >= MIN_PAY) begin
            state_nx = FCS;
            cnt_nx   = 8'd0;
            byte_nx  = fcs_byte(crc, bad, 2'd0);
          end else begin
            crc_en     = 1'b1;
            crc_dat    = 8'h00;
            pay_cnt_nx = sat_inc(pay_cnt);
          end
        end
      end
      FCS: begin
        if (dib == 2'd3) begin
          if (cnt == 8'd3) begin
            state_nx = IFG;
            cnt_nx   = 8'd0;
          end else begin
            cnt_nx  = cnt + 8'd1;
            byte_nx = fcs_byte(crc, bad, cnt[1:0] + 2'd1);
          end
        end
      end
      IFG: begin
        dib_nx = 2'd0;
        if (cnt == IFG_LAST) begin
          state_nx = bad ? DISCARD : IDLE;
          cnt_nx   = 8'd0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      DISCARD: begin
        dib_nx = 2'd0;
        if (s_tvalid && s_tlast) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    tx_en_nx = (state_nx == PREAMBLE) || (state_nx == SFD) || (state_nx == PAYLOAD) ||
               (state_nx == PAD) || (state_nx == FCS);
    txd_nx   = tx_en_nx ? byte_nx[{dib_nx, 1'b0} +: 2] : 2'b00;
    busy_nx  = (state_nx != IDLE) && (state_nx != DISCARD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dib       <= 2'd0;
      cnt       <= 8'd0;
      pay_cnt   <= 16'd0;
      cur_byte  <= 8'h00;
      last_seen <= 1'b0;
      bad       <= 1'b0;
      TX_EN     <= 1'b0;
      TXD       <= 2'b00;
      busy      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_nx;
      dib       <= dib_nx;
      cnt       <= cnt_nx;
      pay_cnt   <= pay_cnt_nx;
      cur_byte  <= byte_nx;
      last_seen <= last_nx;
      bad       <= bad_nx;
      TX_EN     <= tx_en_nx;
      TXD       <= txd_nx;
      busy      <= busy_nx;
      underrun  <= fetch && !s_tvalid;
    end
  end

endmodule
